conv_mac_array: RTL and testbench

CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

---
 rtl/conv_mac_array.sv | 148 ++++++++++++++
 tb/tb_conv_mac_array.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_array.sv
// Multi-lane signed multiply-accumulate array with a shared IDLE/ACCUM/HOLD handshake FSM.
// Optional macro CONV_MAC_SAT_EN: saturating per-lane accumulation with sticky out_sat flags.
module conv_mac_array #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int AW    = 20,
    parameter int KW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KW-1:0]         cfg_klen,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   w_in,
    input  logic [LANES*DW-1:0]   x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*AW-1:0]   out_data,
    output logic [LANES-1:0]      out_sat,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LANES-1:0][AW-1:0] r_acc;
    logic [LANES-1:0][AW-1:0] w_prod;
    logic [LANES-1:0][AW-1:0] w_sum;
    logic [LANES-1:0]        r_sat;
    logic [LANES-1:0]        w_ovf;
    logic [KW-1:0]           r_cnt;
    logic [KW-1:0]           r_klen;
    logic [KW-1:0]           w_klen_in;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_consume;

    // A zero kernel length behaves as a single-product result.
    assign w_klen_in = (cfg_klen == '0) ? KW'(1) : cfg_klen;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DW-1:0]   w_a;
        logic signed [DW-1:0]   w_b;
        logic signed [2*DW-1:0] w_p;

        assign w_a       = w_in[g*DW +: DW];
        assign w_b       = x_in[g*DW +: DW];
        assign w_p       = w_a * w_b;
        assign w_prod[g] = AW'(w_p);

`ifdef CONV_MAC_SAT_EN
        logic [AW:0] w_s;

        // One guard bit: overflow when the two top bits of the widened sum disagree.
        assign w_s      = {r_acc[g][AW-1], r_acc[g]} + {w_prod[g][AW-1], w_prod[g]};
        assign w_ovf[g] = w_s[AW] ^ w_s[AW-1];
        assign w_sum[g] = !w_ovf[g] ? w_s[AW-1:0]
                        : (w_s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
`else
        assign w_sum[g] = r_acc[g] + w_prod[g];
        assign w_ovf[g] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_first     = 1'b1;
                    w_state_nxt = (w_klen_in == KW'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt + KW'(1) == r_klen) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Clear overrides every other event, including a beat offered in the same cycle.
        if (clear) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_first     = 1'b0;
            w_consume   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_sat  <= '0;
            r_cnt  <= '0;
            r_klen <= KW'(1);
        end else if (clear) begin
            r_acc  <= '0;
            r_sat  <= '0;
            r_cnt  <= '0;
        end else if (w_accept && w_first) begin
            r_acc  <= w_prod;
            r_sat  <= '0;
            r_cnt  <= KW'(1);
            r_klen <= w_klen_in;
        end else if (w_accept) begin
            r_acc  <= w_sum;
            r_sat  <= r_sat | w_ovf;
            r_cnt  <= r_cnt + KW'(1);
        end else if (w_consume) begin
            r_sat  <= '0;
            r_cnt  <= '0;
        end
    end

    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array: transaction-level reference model plus directed and random stimulus.
module tb_conv_mac_array;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int KW    = 8;
    localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW-1));

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [KW-1:0]        cfg_klen = '0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LANES*DW-1:0]  w_in = '0;
    logic [LANES*DW-1:0]  x_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [LANES*AW-1:0]  out_data;
    logic [LANES-1:0]     out_sat;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    conv_mac_array #(.LANES(LANES), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_klen(cfg_klen), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: beats of the open result, latched length, pending result.
    bit                   m_pending;
    bit                   m_zero;
    int                   m_n;
    int                   m_klen;
    longint               m_res [LANES];
    bit                   m_sat [LANES];
    logic [LANES*DW-1:0]  m_wq[$];
    logic [LANES*DW-1:0]  m_xq[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint dut_lane(input int i);
        logic signed [AW-1:0] t;
        t = out_data[i*AW +: AW];
        return longint'(t);
    endfunction

    function automatic longint lane_prod(input logic [LANES*DW-1:0] w, input logic [LANES*DW-1:0] x, input int i);
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        a = w[i*DW +: DW];
        b = x[i*DW +: DW];
        return longint'(a) * longint'(b);
    endfunction

    function automatic longint wrap(input longint v);
        longint m;
        longint r;
        m = 64'sd1 <<< AW;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] allb(input int v);
        logic [LANES*DW-1:0] r;
        logic [DW-1:0] b;
        b = DW'(v);
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = b;
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] rnd_vec();
        logic [LANES*DW-1:0] r;
        int sel;
        for (int i = 0; i < LANES; i++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0)      r[i*DW +: DW] = DW'(127);
            else if (sel == 1) r[i*DW +: DW] = DW'(-128);
            else               r[i*DW +: DW] = DW'($urandom);
        end
        return r;
    endfunction

    task automatic m_reset();
        m_pending = 1'b0;
        m_zero    = 1'b1;
        m_n       = 0;
        m_klen    = 1;
        m_wq.delete();
        m_xq.delete();
    endtask

    task automatic m_finish();
        longint acc;
        bit s;
        for (int l = 0; l < LANES; l++) begin
            acc = lane_prod(m_wq[0], m_xq[0], l);
            s = 1'b0;
            for (int k = 1; k < m_wq.size(); k++) begin
                acc = acc + lane_prod(m_wq[k], m_xq[k], l);
`ifdef CONV_MAC_SAT_EN
                if (acc > MAXV) begin acc = MAXV; s = 1'b1; end
                if (acc < MINV) begin acc = MINV; s = 1'b1; end
`else
                acc = wrap(acc);
`endif
            end
            m_res[l] = acc;
            m_sat[l] = s;
        end
    endtask

    task automatic m_step(input bit iv, input bit clr, input bit ord, input int kl,
                          input logic [LANES*DW-1:0] w, input logic [LANES*DW-1:0] x);
        if (clr) begin
            m_reset();
        end else if (m_pending) begin
            if (ord) m_pending = 1'b0;
        end else if (iv) begin
            if (m_n == 0) m_klen = (kl == 0) ? 1 : kl;
            m_wq.push_back(w);
            m_xq.push_back(x);
            m_n++;
            m_zero = 1'b0;
            if (m_n == m_klen) begin
                m_finish();
                m_pending = 1'b1;
                m_n = 0;
                m_wq.delete();
                m_xq.delete();
            end
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then advance the model at the rising edge.
    task automatic cyc(input bit iv, input bit clr, input bit ord, input int kl,
                       input logic [LANES*DW-1:0] w, input logic [LANES*DW-1:0] x);
        @(negedge clk);
        #1;
        in_valid  = iv;
        clear     = clr;
        out_ready = ord;
        cfg_klen  = KW'(kl);
        w_in      = w;
        x_in      = x;
        @(posedge clk);
        if (rst_n) m_step(iv, clr, ord, kl, w, x);
        else       m_reset();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", longint'(in_ready), longint'(!m_pending));
            chk("out_valid", longint'(out_valid), longint'(m_pending));
            chk("busy", longint'(busy), longint'(m_pending || (m_n > 0)));
            if (m_pending) begin
                for (int l = 0; l < LANES; l++) begin
                    chk("out_data", dut_lane(l), m_res[l]);
                    chk("out_sat", longint'(out_sat[l]), longint'(m_sat[l]));
                end
            end else if (m_zero) begin
                for (int l = 0; l < LANES; l++) chk("zero_data", dut_lane(l), 0);
                chk("zero_sat", longint'(out_sat), 0);
            end
`ifndef CONV_MAC_SAT_EN
            chk("sat_off", longint'(out_sat), 0);
`endif
        end
    end

    initial begin
        logic [LANES*DW-1:0] w;
        logic [LANES*DW-1:0] x;
        longint held;

        m_reset();
        #2;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_data", longint'(out_data), 0);
        chk("rst_sat", longint'(out_sat), 0);
        chk("rst_ready", longint'(in_ready), 1);
        cyc(0, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, 0, '0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // klen=3 lane0 (2,3),(-4,5),(7,-1) = -21; later beats carry a different cfg_klen
        w = rnd_vec(); x = rnd_vec(); w[DW-1:0] = DW'(2);  x[DW-1:0] = DW'(3);
        cyc(1, 0, 1, 3, w, x);
        w = rnd_vec(); x = rnd_vec(); w[DW-1:0] = DW'(-4); x[DW-1:0] = DW'(5);
        cyc(1, 0, 1, 7, w, x);
        w = rnd_vec(); x = rnd_vec(); w[DW-1:0] = DW'(7);  x[DW-1:0] = DW'(-1);
        cyc(1, 0, 1, 1, w, x);
        #2;
        chk("k3_valid", longint'(out_valid), 1);
        chk("k3_lane0", dut_lane(0), -21);
        chk("k3_model", m_res[0], -21);
        cyc(0, 0, 1, 3, '0, '0);
        #2;
        chk("k3_idle", longint'(busy), 0);

        // klen=1 with -128 * -128 on every lane
        cyc(1, 0, 0, 1, allb(-128), allb(-128));
        #2;
        for (int l = 0; l < LANES; l++) chk("k1_lane", dut_lane(l), 16384);
        chk("k1_ready", longint'(in_ready), 0);
        cyc(0, 0, 0, 1, '0, '0);
        cyc(0, 0, 1, 1, '0, '0);
        #2;
        chk("k1_done", longint'(out_valid), 0);

        // klen=2 held 5 cycles under backpressure with beats offered
        cyc(1, 0, 0, 2, allb(3), allb(-2));
        cyc(1, 0, 0, 2, allb(-5), allb(-4));
        #2;
        held = dut_lane(0);
        chk("bp_first", held, 14);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 2, rnd_vec(), rnd_vec());
            #2;
            chk("bp_stable", dut_lane(0), held);
            chk("bp_ready", longint'(in_ready), 0);
        end
        cyc(1, 0, 1, 1, allb(9), allb(9));
        #2;
        chk("bp_release", longint'(out_valid), 0);
        chk("bp_nobeat", longint'(busy), 0);
        cyc(1, 0, 1, 1, allb(1), allb(5));
        #2;
        chk("bp_next", dut_lane(2), 5);
        cyc(0, 0, 1, 1, '0, '0);

        // clear after two beats discards everything
        cyc(1, 0, 1, 4, allb(9), allb(9));
        cyc(1, 0, 1, 4, allb(9), allb(9));
        cyc(1, 1, 1, 4, allb(50), allb(50));
        #2;
        chk("clr_valid", longint'(out_valid), 0);
        chk("clr_busy", longint'(busy), 0);
        chk("clr_data", dut_lane(1), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 4, allb(1), allb(1));
        #2;
        for (int l = 0; l < LANES; l++) chk("clr_fresh", dut_lane(l), 4);
        cyc(0, 0, 1, 4, '0, '0);

        // 127*127 four times at AW=16
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 4, allb(127), allb(127));
        #2;
`ifdef CONV_MAC_SAT_EN
        chk("ovf_data", dut_lane(0), 32767);
        chk("ovf_sat", longint'(out_sat[0]), 1);
`else
        chk("ovf_data", dut_lane(0), -1020);
        chk("ovf_sat", longint'(out_sat[0]), 0);
`endif
        cyc(0, 0, 1, 4, '0, '0);

        // klen=0 behaves as 1
        cyc(1, 0, 0, 0, allb(-3), allb(7));
        #2;
        chk("k0_valid", longint'(out_valid), 1);
        chk("k0_lane", dut_lane(3), -21);
        cyc(0, 0, 1, 0, '0, '0);

        // asynchronous reset between edges mid-accumulation
        cyc(1, 0, 1, 4, allb(11), allb(13));
        cyc(1, 0, 1, 4, allb(11), allb(13));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", longint'(out_data), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_valid", longint'(out_valid), 0);
        m_reset();
        cyc(0, 0, 1, 2, '0, '0);
        cyc(0, 0, 1, 2, '0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1, 0, 1, 2, allb(3), allb(4));
        cyc(1, 0, 1, 2, allb(5), allb(6));
        #2;
        chk("arst_fresh", dut_lane(0), 42);
        cyc(0, 0, 1, 2, '0, '0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 5), rnd_vec(), rnd_vec());
        end
        cyc(0, 0, 1, 1, '0, '0);
        cyc(0, 0, 1, 1, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
